// File: rtl/bilinear_pkg.sv
// Shared constants, FSM state encoding and the per-axis coordinate mapper
// for the SIMD bilinear scaler.
package bilinear_pkg;
  localparam int FRAC_BITS = 8;
  localparam int ONE_Q     = 256;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_INTERP, S_WRITE, S_DONE} state_e;

  typedef struct packed {
    logic [15:0] in_w;
    logic [15:0] in_h;
    logic [15:0] out_w;
    logic [15:0] out_h;
    logic [15:0] inv;
  } cfg_t;

  typedef struct packed {
    logic [15:0]          i0;
    logic [15:0]          i1;
    logic [FRAC_BITS-1:0] f;
  } axis_t;

  // Source coordinate for one axis; past the edge the index pins to size-1
  // and the fraction is dropped so no neighbour leaves the image.
  function automatic axis_t axis_map(input logic [16:0] c, input logic [15:0] inv,
                                     input logic [15:0] size);
    logic [32:0] s;
    logic [24:0] ip;
    logic [15:0] lim;
    axis_t       a;
    s   = 33'(c) * 33'(inv);
    ip  = s[32:FRAC_BITS];
    lim = size - 16'd1;
    if (ip > 25'(lim)) begin
      a.i0 = lim;
      a.f  = '0;
    end else begin
      a.i0 = ip[15:0];
      a.f  = s[FRAC_BITS-1:0];
    end
    a.i1 = (a.i0 < lim) ? a.i0 + 16'd1 : lim;
    return a;
  endfunction
endpackage

// File: rtl/bilinear_lane.sv
// One output lane: clamps its source coordinates, forms the four neighbour
// addresses and blends the returned pixels (purely combinational).
module bilinear_lane
  import bilinear_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 32
) (
  input  logic [16:0]         ox,
  input  logic [15:0]         oy,
  input  logic [15:0]         in_w,
  input  logic [15:0]         in_h,
  input  logic [15:0]         inv_scale_q,
  input  logic [4*PIX_W-1:0]  nb_data,
  output logic [4*ADDR_W-1:0] nb_addr,
  output logic [PIX_W-1:0]    pix
);
  localparam int W = 2*PIX_W + 10;

  axis_t        ax, ay;
  logic [W-1:0] p00, p01, p10, p11, wx0, wx1, wy0, wy1, top, bot, acc;

  function automatic logic [ADDR_W-1:0] lin(input logic [15:0] y, input logic [15:0] x,
                                            input logic [15:0] w);
    return ADDR_W'(y) * ADDR_W'(w) + ADDR_W'(x);
  endfunction

  assign ax = axis_map(ox, inv_scale_q, in_w);
  assign ay = axis_map({1'b0, oy}, inv_scale_q, in_h);

  assign nb_addr = {lin(ay.i1, ax.i1, in_w), lin(ay.i1, ax.i0, in_w),
                    lin(ay.i0, ax.i1, in_w), lin(ay.i0, ax.i0, in_w)};

  assign p00 = W'(nb_data[0*PIX_W +: PIX_W]);
  assign p01 = W'(nb_data[1*PIX_W +: PIX_W]);
  assign p10 = W'(nb_data[2*PIX_W +: PIX_W]);
  assign p11 = W'(nb_data[3*PIX_W +: PIX_W]);

  assign wx1 = W'(ax.f);
  assign wx0 = W'(ONE_Q) - wx1;
  assign wy1 = W'(ay.f);
  assign wy0 = W'(ONE_Q) - wy1;

  assign top = p00 * wx0 + p01 * wx1;
  assign bot = p10 * wx0 + p11 * wx1;
  assign acc = top * wy0 + bot * wy1 + (W'(1) << (2*FRAC_BITS - 1));
  assign pix = PIX_W'(acc >> (2*FRAC_BITS));
endmodule

// File: rtl/bilinear_core_simd.sv
// Bilinear scaler control: walks the output frame LANES pixels at a time,
// three states per group, with an optional single-step handshake.
module bilinear_core_simd
  import bilinear_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [15:0]               in_w,
  input  logic [15:0]               in_h,
  input  logic [15:0]               out_w,
  input  logic [15:0]               out_h,
  input  logic [15:0]               inv_scale_q,
  input  logic                      start,
  input  logic                      step_mode,
  input  logic                      step,
  output logic                      step_ack,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [4*LANES*ADDR_W-1:0] rd_addr,
  input  logic [4*LANES*PIX_W-1:0]  rd_data,
  output logic                      wr_valid,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [LANES*PIX_W-1:0]    wr_data,
  output logic [LANES-1:0]          wr_mask
);
  state_e                           state_q, state_d;
  cfg_t                             cfg_q, cfg_d;
  logic [15:0]                      gx_q, gx_d, oy_q, oy_d;
  logic                             step_mode_q, step_mode_d, step_ack_q, step_ack_d;
  logic                             err_q, err_d, wr_valid_q, wr_valid_d;
  logic [4*LANES*ADDR_W-1:0]        rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]                wr_addr_q, wr_addr_d;
  logic [LANES*PIX_W-1:0]           wr_data_q, wr_data_d;
  logic [LANES-1:0]                 wr_mask_q, wr_mask_d;

  logic [LANES-1:0][4*ADDR_W-1:0]   lane_addr;
  logic [LANES-1:0][PIX_W-1:0]      lane_pix;
  logic [LANES-1:0]                 lane_on;
  logic                             cfg_ok, launch, adv, fire, last_col, last_row;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [16:0] ox;
    assign ox         = {1'b0, gx_q} + 17'(l);
    assign lane_on[l] = ox < {1'b0, cfg_q.out_w};
    bilinear_lane #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) u_lane (
      .ox          (ox),
      .oy          (oy_q),
      .in_w        (cfg_q.in_w),
      .in_h        (cfg_q.in_h),
      .inv_scale_q (cfg_q.inv),
      .nb_data     (rd_data[l*4*PIX_W +: 4*PIX_W]),
      .nb_addr     (lane_addr[l]),
      .pix         (lane_pix[l])
    );
  end

  always_comb begin
    cfg_ok   = (in_w != 0) && (in_h != 0) && (out_w != 0) && (out_h != 0) && (inv_scale_q != 0);
    // In step mode the launch itself consumes a step, so a frame of G groups
    // takes 3*G+1 acknowledged steps.
    launch   = start && (!step_mode || (step && !step_ack_q));
    adv      = !step_mode_q || (step && !step_ack_q);
    last_col = ({1'b0, gx_q} + 17'(LANES)) >= {1'b0, cfg_q.out_w};
    last_row = ({1'b0, oy_q} + 17'd1) >= {1'b0, cfg_q.out_h};

    state_d     = state_q;
    cfg_d       = cfg_q;
    gx_d        = gx_q;
    oy_d        = oy_q;
    step_mode_d = step_mode_q;
    err_d       = err_q;
    rd_addr_d   = rd_addr_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_mask_d   = wr_mask_q;
    wr_valid_d  = 1'b0;
    fire        = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: if (launch) begin
        cfg_d       = {in_w, in_h, out_w, out_h, inv_scale_q};
        step_mode_d = step_mode;
        gx_d        = '0;
        oy_d        = '0;
        fire        = step_mode;
        err_d       = !cfg_ok;
        state_d     = cfg_ok ? S_ADDR : S_DONE;
      end
      S_ADDR: if (adv) begin
        fire    = step_mode_q;
        state_d = S_INTERP;
        for (int l = 0; l < LANES; l++)
          rd_addr_d[l*4*ADDR_W +: 4*ADDR_W] = lane_on[l] ? lane_addr[l] : '0;
      end
      S_INTERP: if (adv) begin
        fire       = step_mode_q;
        state_d    = S_WRITE;
        wr_valid_d = 1'b1;
        wr_addr_d  = ADDR_W'(oy_q) * ADDR_W'(cfg_q.out_w) + ADDR_W'(gx_q);
        wr_mask_d  = lane_on;
        for (int l = 0; l < LANES; l++)
          wr_data_d[l*PIX_W +: PIX_W] = lane_on[l] ? lane_pix[l] : '0;
      end
      S_WRITE: if (adv) begin
        fire = step_mode_q;
        if (last_col) begin
          gx_d = '0;
          if (last_row) state_d = S_DONE;
          else begin
            oy_d    = oy_q + 16'd1;
            state_d = S_ADDR;
          end
        end else begin
          gx_d    = gx_q + 16'(LANES);
          state_d = S_ADDR;
        end
      end
      default: state_d = S_IDLE;
    endcase

    step_ack_d = step_ack_q ? step : fire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cfg_q       <= '0;
      gx_q        <= '0;
      oy_q        <= '0;
      step_mode_q <= 1'b0;
      step_ack_q  <= 1'b0;
      err_q       <= 1'b0;
      wr_valid_q  <= 1'b0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_mask_q   <= '0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      gx_q        <= gx_d;
      oy_q        <= oy_d;
      step_mode_q <= step_mode_d;
      step_ack_q  <= step_ack_d;
      err_q       <= err_d;
      wr_valid_q  <= wr_valid_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_mask_q   <= wr_mask_d;
    end
  end

  assign busy     = state_q inside {S_ADDR, S_INTERP, S_WRITE};
  assign done     = state_q == S_DONE;
  assign err      = err_q;
  assign step_ack = step_ack_q;
  // A pending write is suppressed in the very cycle reset is raised.
  assign wr_valid = wr_valid_q && !rst;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_mask  = wr_mask_q;
  assign rd_addr  = rd_addr_q;
endmodule
